// File: rtl/xgmii_frame_gen.sv
// xgmii_frame_gen: XGMII test-frame generator.
// Each frame goes out as a START word, FRAME_WORDS data words (Ethernet
// header, 32-bit run sequence number, then an incrementing byte pattern), a
// TERM word carrying the CRC-32 FCS, and IFG_WORDS all-idle words.
//
// Ports
//   clk          156.25 MHz XGMII TX clock; everything runs on its rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse; begins a run (ignored while busy)
//   stop         one-cycle pulse; ends the run after the current frame
//   frame_count  frames per run, sampled on start (0 = continuous)
//   xgmii_txd    64-bit XGMII data; lane 0 = bits 7:0, first on the wire
//   xgmii_txc    XGMII control flag per lane
//   busy         high from the first START word through the last IFG word
//   done         one-cycle pulse in the first IDLE cycle after a run
//   frames_sent  total frames emitted, wraps modulo 2^32
//   fsm_state    current FSM state (debug)
//
// Control handshake: start/stop are plain single-cycle pulses with no ready;
// start is only acted on while busy is low.
module xgmii_frame_gen #(
  parameter int          FRAME_WORDS = 8,
  parameter int          IFG_WORDS   = 2,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h020000000000,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_count,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        busy,
  output logic        done,
  output logic [31:0] frames_sent,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_IFG} state_t;

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam logic [15:0] LAST_WORD  = 16'(FRAME_WORDS - 1);
  localparam logic [15:0] LAST_IFG   = 16'(IFG_WORDS - 1);

  state_t      state, state_nxt;
  logic [15:0] word_idx;   // index of the data word currently on txd
  logic [15:0] ifg_cnt;
  logic [31:0] seq;        // frames completed in this run = sequence number
  logic [15:0] run_len;
  logic        stop_pend;
  logic [31:0] crc;        // running CRC including the word currently on txd
  logic        run_more;
  logic [15:0] nxt_idx;
  logic [63:0] nxt_data;

  // Frame byte k: 18-byte header (DST, SRC, EtherType, sequence), then k[7:0].
  function automatic logic [63:0] data_word(input logic [15:0] w, input logic [31:0] s);
    logic [143:0] hdr;
    logic [143:0] sh;
    logic [31:0]  k;
    logic [63:0]  d;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE, s};
    d   = '0;
    for (int l = 0; l < 8; l++) begin
      k = {13'd0, w, 3'd0} + 32'(l);
      if (k < 32'd18) begin
        sh = hdr >> ((32'd17 - k) << 3);
        d[8*l +: 8] = sh[7:0];
      end else begin
        d[8*l +: 8] = k[7:0];
      end
    end
    return d;
  endfunction

  // Reflected CRC-32, bits consumed lane 0 first, LSB first within a lane.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [63:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 64; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    state_nxt = state;
    run_more  = (run_len == 16'd0) || (seq != {16'd0, run_len});
    nxt_idx   = (state == S_DATA) ? word_idx + 16'd1 : 16'd0;
    nxt_data  = data_word(nxt_idx, seq);
    case (state)
      S_IDLE:  if (start && !stop) state_nxt = S_START;
      S_START: state_nxt = S_DATA;
      S_DATA:  if (word_idx == LAST_WORD) state_nxt = S_TERM;
      S_TERM:  state_nxt = S_IFG;
      S_IFG: begin
        // A stop arriving in the final IFG cycle still counts.
        if (ifg_cnt == LAST_IFG)
          state_nxt = (run_more && !stop_pend && !stop) ? S_START : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      word_idx    <= '0;
      ifg_cnt     <= '0;
      seq         <= '0;
      run_len     <= '0;
      stop_pend   <= 1'b0;
      crc         <= '0;
      xgmii_txd   <= IDLE_WORD;
      xgmii_txc   <= 8'hFF;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state == S_IFG) && (state_nxt == S_IDLE);

      if (state == S_IDLE && state_nxt == S_START) begin
        seq     <= '0;
        run_len <= frame_count;
      end

      if (state_nxt == S_IDLE)
        stop_pend <= 1'b0;
      else if (stop && state != S_IDLE)
        stop_pend <= 1'b1;

      if (state_nxt == S_DATA) word_idx <= nxt_idx;
      if (state_nxt == S_IFG)  ifg_cnt  <= (state == S_IFG) ? ifg_cnt + 16'd1 : 16'd0;

      if (state_nxt == S_START)     crc <= 32'hFFFFFFFF;
      else if (state_nxt == S_DATA) crc <= crc_step(crc, nxt_data);

      if (state_nxt == S_TERM) begin
        seq         <= seq + 32'd1;
        frames_sent <= frames_sent + 32'd1;
      end

      case (state_nxt)
        S_START: begin xgmii_txd <= START_WORD; xgmii_txc <= 8'h01; end
        S_DATA:  begin xgmii_txd <= nxt_data;   xgmii_txc <= 8'h00; end
        S_TERM:  begin xgmii_txd <= {24'h070707, 8'hFD, ~crc}; xgmii_txc <= 8'hF0; end
        default: begin xgmii_txd <= IDLE_WORD;  xgmii_txc <= 8'hFF; end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_xgmii_frame_gen.sv
// tb_xgmii_frame_gen: drives runs of frames into xgmii_frame_gen and compares
// every output word against a byte-level frame model (header fields, pattern
// bytes, byte-serial CRC-32) built in queues.
module tb_xgmii_frame_gen;

  localparam int          FW   = 8;
  localparam int          IFG  = 2;
  localparam int          P    = FW + 2 + IFG;
  localparam logic [47:0] DST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC  = 48'h020000000000;
  localparam logic [15:0] ETH  = 16'h88B5;
  localparam logic [63:0] IDLE = 64'h0707070707070707;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_count = '0;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy, done;
  logic [31:0] frames_sent;
  logic [2:0]  fsm_state;

  xgmii_frame_gen #(
    .FRAME_WORDS(FW), .IFG_WORDS(IFG), .DST_MAC(DST), .SRC_MAC(SRC), .ETHERTYPE(ETH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .frame_count(frame_count),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .busy(busy), .done(done),
    .frames_sent(frames_sent), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [63:0] exp_q[$];
  logic [7:0]  exp_c_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_sent = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: one complete frame period, byte by byte.
  task automatic push_frame(input logic [31:0] seq);
    logic [7:0]  fb[0:8*FW-1];
    logic [31:0] c;
    logic [63:0] w;
    for (int k = 0; k < 8*FW; k++) begin
      if (k < 6)       fb[k] = 8'(DST >> (8*(5 - k)));
      else if (k < 12) fb[k] = 8'(SRC >> (8*(11 - k)));
      else if (k < 14) fb[k] = 8'(ETH >> (8*(13 - k)));
      else if (k < 18) fb[k] = 8'(seq >> (8*(17 - k)));
      else             fb[k] = 8'(k);
    end
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 8*FW; k++) begin
      c = c ^ {24'd0, fb[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    exp_q.push_back(64'hD5555555555555FB); exp_c_q.push_back(8'h01);
    for (int i = 0; i < FW; i++) begin
      for (int l = 0; l < 8; l++) w[8*l +: 8] = fb[8*i + l];
      exp_q.push_back(w); exp_c_q.push_back(8'h00);
    end
    exp_q.push_back({8'h07, 8'h07, 8'h07, 8'hFD, c[31:24], c[23:16], c[15:8], c[7:0]});
    exp_c_q.push_back(8'hF0);
    for (int i = 0; i < IFG; i++) begin
      exp_q.push_back(IDLE); exp_c_q.push_back(8'hFF);
    end
  endtask

  // driver: one run; stop_at/start_at are output-cycle indices (-1 = none)
  task automatic run_case(input int fc, input int stop_at, input int start_at);
    int          frames, total;
    logic [63:0] ed;
    logic [7:0]  ec;
    frames = fc;
    if (stop_at >= 0) begin
      frames = stop_at / P + 1;
      if (fc != 0 && fc < frames) frames = fc;
    end
    total = frames * P;
    for (int f = 0; f < frames; f++) push_frame(32'(f));
    start = 1'b1; frame_count = 16'(fc);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < total; c++) begin
      ed = exp_q.pop_front();
      ec = exp_c_q.pop_front();
      if (ec == 8'hF0) exp_sent = exp_sent + 32'd1;
      check("txd", xgmii_txd, ed);
      check("txc", {56'd0, xgmii_txc}, {56'd0, ec});
      check("busy", {63'd0, busy}, 64'd1);
      check("done_low", {63'd0, done}, 64'd0);
      check("frames_sent", {32'd0, frames_sent}, {32'd0, exp_sent});
      if (c == 1) check("hdr_word0", xgmii_txd, 64'h0002FFFFFFFFFFFF);
      if (c == 2) check("hdr_word1", xgmii_txd, 64'h0000B58800000000);
      stop  = (c == stop_at);
      start = (c == start_at);
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
    end
    check("end_txd", xgmii_txd, IDLE);
    check("end_busy", {63'd0, busy}, 64'd0);
    check("end_done", {63'd0, done}, 64'd1);
    check("end_sent", {32'd0, frames_sent}, {32'd0, exp_sent});
    @(negedge clk);
    check("done_once", {63'd0, done}, 64'd0);
    check("idle_txc", {56'd0, xgmii_txc}, 64'hFF);
  endtask

  initial begin
    int fc, stop_at, start_at, frames;
    #2 rst_n = 1'b0;
    #1;
    check("rst_txd", xgmii_txd, IDLE);
    check("rst_txc", {56'd0, xgmii_txc}, 64'hFF);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_sent", {32'd0, frames_sent}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_case(1, -1, -1);          // single frame
    run_case(3, -1, -1);          // back-to-back, sequence 0..2
    run_case(0, P + 3, -1);       // continuous, stop in DATA of frame 2
    run_case(3, -1, 5);           // start while busy is ignored

    // start and stop together in IDLE: nothing happens
    start = 1'b1; stop = 1'b1; frame_count = 16'd2;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (4) begin
      check("ss_txd", xgmii_txd, IDLE);
      check("ss_busy", {63'd0, busy}, 64'd0);
      check("ss_sent", {32'd0, frames_sent}, {32'd0, exp_sent});
      @(negedge clk);
    end

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      fc = $urandom_range(0, 4);
      stop_at = -1;
      if (fc == 0 || $urandom_range(0, 1) == 1)
        stop_at = $urandom_range(0, ((fc == 0) ? 3 : fc) * P - 1);
      frames = fc;
      if (stop_at >= 0) begin
        frames = stop_at / P + 1;
        if (fc != 0 && fc < frames) frames = fc;
      end
      start_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, frames * P - 1) : -1;
      run_case(fc, stop_at, start_at);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // reset in the 4th DATA word truncates the frame
    push_frame(32'd0);
    start = 1'b1; frame_count = 16'd1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("pre_rst_txd", xgmii_txd, exp_q.pop_front());
      if (c < 4) @(negedge clk);
    end
    exp_q.delete();
    exp_c_q.delete();
    #1 rst_n = 1'b0;
    exp_sent = '0;
    #1;
    check("mid_rst_txd", xgmii_txd, IDLE);
    check("mid_rst_txc", {56'd0, xgmii_txc}, 64'hFF);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_sent", {32'd0, frames_sent}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("post_rst_txc", {56'd0, xgmii_txc}, 64'hFF);
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    check("post_rst_sent", {32'd0, frames_sent}, {32'd0, exp_sent});

    run_case(2, -1, -1);          // fresh run after reset, sequence restarts at 0

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
